// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard frame receiver that turns arrow-key makes into one-hot move
// requests (valid/ready) and tracks the 's' key as a held start level.
module ps2_move_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [3:0] direction,
  output logic       move_valid,
  input  logic       move_ready,
  output logic       start,
  output logic       frame_err,
  output logic [1:0] fsm_state
);

  // Handshake: direction is held stable while move_valid=1; a move transfers on
  // any rising edge with move_valid=1 and move_ready=1. A move decoded while a
  // transfer happens replaces it; one decoded while stalled is dropped.

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          state, state_next;
  logic            clk_s1, clk_s2, clk_prev;
  logic            dat_s1, dat_s2;
  logic [3:0]      bit_cnt;
  logic [9:0]      frame;
  logic [CW-1:0]   idle_cnt;
  logic            ext, brk;
  logic [3:0]      held_dir;
  logic            held_s;
  logic            fall, timeout, byte_ok, accept, is_prefix, err_next;
  logic [7:0]      code;
  logic [3:0]      key_dir;
  logic            key_s;
  logic            new_move;

  assign fall      = clk_prev & ~clk_s2;
  assign code      = frame[7:0];
  // frame[8] is parity, frame[9] is stop; odd parity over data+parity
  assign byte_ok   = (^frame[8:0]) & frame[9];
  assign timeout   = (idle_cnt == CW'(TIMEOUT_CYCLES));
  assign accept    = (state == CHECK) && byte_ok;
  assign is_prefix = (code == 8'hE0) || (code == 8'hF0);
  assign new_move  = accept && !is_prefix && !brk && (key_dir != 4'b0) &&
                     ((held_dir & key_dir) == 4'b0);
  assign start     = held_s;
  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat;
      dat_s2   <= dat_s1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      frame_err <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      IDLE:  if (fall && !dat_s2) state_next = RECV;
      RECV: begin
        if (timeout) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end else if (fall && bit_cnt == 4'd9) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        state_next = IDLE;
        err_next   = !byte_ok;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      bit_cnt  <= 4'd0;
      frame    <= 10'd0;
      idle_cnt <= '0;
    end else if (state == RECV) begin
      if (fall) begin
        frame[bit_cnt] <= dat_s2;
        bit_cnt        <= bit_cnt + 4'd1;
        idle_cnt       <= '0;
      end else if (!timeout) begin
        idle_cnt <= idle_cnt + CW'(1);
      end
    end else begin
      bit_cnt  <= 4'd0;
      idle_cnt <= '0;
    end
  end

  // Arrows only exist behind the E0 prefix; 's' only without it
  always_comb begin
    key_dir = 4'b0000;
    key_s   = 1'b0;
    if (ext) begin
      case (code)
        8'h75:   key_dir = 4'b1000;
        8'h72:   key_dir = 4'b0100;
        8'h6B:   key_dir = 4'b0010;
        8'h74:   key_dir = 4'b0001;
        default: key_dir = 4'b0000;
      endcase
    end else begin
      key_s = (code == 8'h1B);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      held_dir <= 4'b0;
      held_s   <= 1'b0;
    end else if (state == RECV && timeout) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (accept) begin
      if (code == 8'hE0) begin
        ext <= 1'b1;
      end else if (code == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (brk) begin
          held_dir <= held_dir & ~key_dir;
          held_s   <= held_s & ~key_s;
        end else begin
          held_dir <= held_dir | key_dir;
          held_s   <= held_s | key_s;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      direction  <= 4'b0;
      move_valid <= 1'b0;
    end else if (new_move && (!move_valid || move_ready)) begin
      direction  <= key_dir;
      move_valid <= 1'b1;
    end else if (move_valid && move_ready) begin
      direction  <= 4'b0;
      move_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Bench for ps2_move_decoder: directed scenarios plus a randomized byte stream
// compared against a key-level model of held keys, prefixes and pending moves.
module tb_ps2_move_decoder;

  localparam int TO = 300;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       move_ready = 1'b0;
  logic [3:0] direction;
  logic       move_valid;
  logic       start;
  logic       frame_err;
  logic [1:0] fsm_state;

  ps2_move_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .direction(direction), .move_valid(move_valid), .move_ready(move_ready),
    .start(start), .frame_err(frame_err), .fsm_state(fsm_state)
  );

  always #10 clock = ~clock;

  int n_cmp = 0, n_fail = 0;
  int err_seen = 0, hs_seen = 0;
  logic [3:0] last_hs_dir = 4'b0;

  always @(negedge clock) begin
    if (frame_err) err_seen++;
    if (move_valid && move_ready) begin
      hs_seen++;
      last_hs_dir = direction;
    end
  end

  // reference model
  bit         m_ext, m_brk, m_held_s;
  bit   [3:0] m_held;
  logic [3:0] exp_q[$];
  int         exp_err = 0, exp_hs = 0;
  logic [3:0] exp_last = 4'b0;
  logic       v_at_check, v_after;
  int         chk_j;

  function automatic int key_of(bit ext, logic [7:0] b);
    if (!ext) return (b == 8'h1B) ? 4 : -1;
    case (b)
      8'h75:   return 3;
      8'h72:   return 2;
      8'h6B:   return 1;
      8'h74:   return 0;
      default: return -1;
    endcase
  endfunction

  function automatic logic exp_valid();
    return exp_q.size() != 0;
  endfunction

  function automatic logic [3:0] exp_dir();
    return (exp_q.size() != 0) ? exp_q[0] : 4'b0;
  endfunction

  // mode 0: ready low; 1: ready pulsed in the decode cycle; 2: ready held high
  task automatic model_byte(input logic [7:0] b, input bit ok, input int mode);
    int k;
    bit mv;
    logic [3:0] d;
    if (!ok) begin
      exp_err++;
      return;
    end
    if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      k  = key_of(m_ext, b);
      mv = 0;
      d  = 4'b0;
      if (k == 4) begin
        m_held_s = !m_brk;
      end else if (k >= 0) begin
        d = 4'b0001 << k;
        if (m_brk) m_held[k] = 0;
        else begin
          if (!m_held[k]) mv = 1;
          m_held[k] = 1;
        end
      end
      m_ext = 0;
      m_brk = 0;
      if (mode == 0) begin
        if (mv && exp_q.size() == 0) exp_q.push_back(d);
      end else if (mode == 1) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (mv) exp_q.push_back(d);
      end else if (mv) begin
        exp_hs++;
        exp_last = d;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int mode, input int nbits);
    logic [10:0] bits;
    bits  = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    chk_j = -10;
    v_at_check = 1'bx;
    v_after    = 1'bx;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock);
      ps2_dat = bits[i];
      repeat (4) @(negedge clock);
      ps2_clk = 1'b0;
      for (int j = 0; j < 6; j++) begin
        @(negedge clock);
        if (i == 10) begin
          if (fsm_state == 2'd2) begin
            v_at_check = move_valid;
            chk_j = j;
          end else if (j == chk_j + 1) begin
            v_after = move_valid;
          end
          if (mode == 1) move_ready = (fsm_state == 2'd2);
        end
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int mode);
    send_frame(b, bad_par, bad_stop, mode, 11);
    model_byte(b, !bad_par && !bad_stop, mode);
  endtask

  task automatic pulse_ready();
    @(negedge clock);
    move_ready = 1'b1;
    @(negedge clock);
    move_ready = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    move_ready = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    m_ext = 0; m_brk = 0; m_held = 4'b0; m_held_s = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    n_cmp++; if (direction !== 4'b0) begin n_fail++; $display("FAIL reset_dir got %b want 0000", direction); end
    n_cmp++; if (move_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", move_valid); end
    n_cmp++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", start); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", frame_err); end
    n_cmp++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", fsm_state); end
  endtask

  task automatic test_up_pending();
    send_byte(8'hE0, 0, 0, 0);
    send_byte(8'h75, 0, 0, 0);
    n_cmp++; if (v_at_check !== 1'b0 || v_after !== 1'b1) begin
      n_fail++; $display("FAIL up_latency got check=%b next=%b want 0/1", v_at_check, v_after); end
    repeat (20) @(negedge clock);
    n_cmp++; if (move_valid !== exp_valid()) begin n_fail++; $display("FAIL up_valid got %b want %b", move_valid, exp_valid()); end
    n_cmp++; if (direction !== exp_dir()) begin n_fail++; $display("FAIL up_dir got %b want %b", direction, exp_dir()); end
    pulse_ready();
    n_cmp++; if (move_valid !== 1'b0 || direction !== 4'b0) begin
      n_fail++; $display("FAIL up_consume got v=%b d=%b want 0/0000", move_valid, direction); end
  endtask

  task automatic test_repeat();
    int h0, eh0;
    logic [7:0] seq [11] = '{8'hE0, 8'h6B, 8'hE0, 8'h6B, 8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h6B, 8'hE0, 8'h00};
    h0 = hs_seen; eh0 = exp_hs;
    @(negedge clock); move_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(seq[i], 0, 0, 2);
    @(negedge clock); move_ready = 1'b0;
    n_cmp++; if (hs_seen - h0 !== exp_hs - eh0) begin
      n_fail++; $display("FAIL repeat_moves got %0d want %0d", hs_seen - h0, exp_hs - eh0); end
    n_cmp++; if (last_hs_dir !== exp_last) begin n_fail++; $display("FAIL repeat_dir got %b want %b", last_hs_dir, exp_last); end
    n_cmp++; if (move_valid !== 1'b0) begin n_fail++; $display("FAIL repeat_valid got %b want 0", move_valid); end
  endtask

  task automatic test_start_err();
    int e0, x0;
    e0 = err_seen; x0 = exp_err;
    send_byte(8'h1B, 1, 0, 0);
    n_cmp++; if (err_seen - e0 !== exp_err - x0) begin n_fail++; $display("FAIL par_err got %0d want %0d", err_seen - e0, exp_err - x0); end
    n_cmp++; if (start !== m_held_s) begin n_fail++; $display("FAIL par_start got %b want %b", start, m_held_s); end
    send_byte(8'h1B, 0, 0, 0);
    n_cmp++; if (start !== m_held_s) begin n_fail++; $display("FAIL s_make got %b want %b", start, m_held_s); end
    send_byte(8'hF0, 0, 0, 0);
    send_byte(8'h1B, 0, 0, 0);
    n_cmp++; if (start !== m_held_s) begin n_fail++; $display("FAIL s_break got %b want %b", start, m_held_s); end
    e0 = err_seen; x0 = exp_err;
    send_byte(8'h1B, 0, 1, 0);
    n_cmp++; if (err_seen - e0 !== exp_err - x0) begin n_fail++; $display("FAIL stop_err got %0d want %0d", err_seen - e0, exp_err - x0); end
  endtask

  task automatic test_timeout();
    int e0;
    bit got;
    send_byte(8'hE0, 0, 0, 0);
    send_frame(8'h74, 0, 0, 0, 6);
    e0 = err_seen; got = 0;
    for (int c = 0; c < TO + 100 && !got; c++) begin
      @(negedge clock);
      if (frame_err) got = 1;
    end
    m_ext = 0; m_brk = 0; exp_err++;
    repeat (4) @(negedge clock);
    n_cmp++; if (!got || err_seen - e0 !== 1) begin n_fail++; $display("FAIL timeout_err got %0d pulses want 1", err_seen - e0); end
    n_cmp++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL timeout_state got %0d want 0", fsm_state); end
    send_byte(8'h74, 0, 0, 0);
    n_cmp++; if (move_valid !== exp_valid()) begin n_fail++; $display("FAIL timeout_noext got %b want %b", move_valid, exp_valid()); end
    send_byte(8'hE0, 0, 0, 0);
    send_byte(8'h74, 0, 0, 0);
    n_cmp++; if (move_valid !== exp_valid() || direction !== exp_dir()) begin
      n_fail++; $display("FAIL timeout_right got %b/%b want %b/%b", move_valid, direction, exp_valid(), exp_dir()); end
    pulse_ready();
  endtask

  task automatic test_back_to_back();
    send_byte(8'hE0, 0, 0, 0); send_byte(8'hF0, 0, 0, 0); send_byte(8'h75, 0, 0, 0);
    send_byte(8'hE0, 0, 0, 0); send_byte(8'h75, 0, 0, 0);
    send_byte(8'hE0, 0, 0, 0); send_byte(8'h72, 0, 0, 0);
    n_cmp++; if (direction !== exp_dir() || move_valid !== exp_valid()) begin
      n_fail++; $display("FAIL drop_dir got %b/%b want %b/%b", direction, move_valid, exp_dir(), exp_valid()); end
    send_byte(8'hE0, 0, 0, 0); send_byte(8'hF0, 0, 0, 0); send_byte(8'h72, 0, 0, 0);
    send_byte(8'hE0, 0, 0, 0); send_byte(8'h72, 0, 0, 1);
    n_cmp++; if (direction !== exp_dir() || move_valid !== exp_valid()) begin
      n_fail++; $display("FAIL hs_load got %b/%b want %b/%b", direction, move_valid, exp_dir(), exp_valid()); end
    pulse_ready();
    n_cmp++; if (move_valid !== 1'b0) begin n_fail++; $display("FAIL hs_consume got %b want 0", move_valid); end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h1B, 0, 0, 0);
    send_byte(8'hE0, 0, 0, 0); send_byte(8'h6B, 0, 0, 0);
    n_cmp++; if (start !== 1'b1 || move_valid !== exp_valid()) begin
      n_fail++; $display("FAIL pre_reset got s=%b v=%b want 1/%b", start, move_valid, exp_valid()); end
    send_frame(8'hE0, 0, 0, 0, 4);
    do_reset();
    @(negedge clock);
    n_cmp++; if (start !== 1'b0 || move_valid !== 1'b0 || direction !== 4'b0) begin
      n_fail++; $display("FAIL mid_reset got s=%b v=%b d=%b want 0/0/0000", start, move_valid, direction); end
    send_byte(8'hE0, 0, 0, 0); send_byte(8'h75, 0, 0, 0);
    n_cmp++; if (direction !== exp_dir() || move_valid !== exp_valid()) begin
      n_fail++; $display("FAIL post_reset got %b/%b want %b/%b", direction, move_valid, exp_dir(), exp_valid()); end
    pulse_ready();
  endtask

  task automatic test_random();
    logic [7:0] pick [8] = '{8'hE0, 8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1B};
    logic [7:0] b;
    bit bp, bs;
    int e0, x0, r;
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 9);
      b = (r < 8) ? pick[r] : 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 9) == 0);
      bs = ($urandom_range(0, 19) == 0);
      e0 = err_seen; x0 = exp_err;
      send_byte(b, bp, bs, 0);
      n_cmp++; if (move_valid !== exp_valid() || direction !== exp_dir()) begin
        n_fail++; $display("FAIL rnd_move n=%0d byte=%h got %b/%b want %b/%b", n, b, move_valid, direction, exp_valid(), exp_dir()); end
      n_cmp++; if (start !== m_held_s) begin n_fail++; $display("FAIL rnd_start n=%0d got %b want %b", n, start, m_held_s); end
      n_cmp++; if (err_seen - e0 !== exp_err - x0) begin
        n_fail++; $display("FAIL rnd_err n=%0d got %0d want %0d", n, err_seen - e0, exp_err - x0); end
      if ($urandom_range(0, 2) == 0) begin
        pulse_ready();
        n_cmp++; if (move_valid !== 1'b0 || direction !== 4'b0) begin
          n_fail++; $display("FAIL rnd_consume n=%0d got %b/%b want 0/0000", n, move_valid, direction); end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up_pending();
    test_repeat();
    test_start_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
